mips_mc_ctrl: RTL
=================

Name: mips_mc_ctrl

Overview:
- Multi-cycle control unit for the next-generation MIPS core. Replaces the single-cycle decode with a per-instruction state machine.
- Shares one ALU across PC increment, address generation and execute. Drives the existing datapath muxes.
- Handles variable-latency instruction and data memory through req/ready handshakes, with a watchdog timeout.
- Sits between the IR/status flags and every datapath enable/select in the core top.

Parameters:
- TMO_W, 4, width of the memory-wait watchdog counter.
- MEM_TMO, 12, maximum wait cycles for ready before bus error. Legal range 1..2^TMO_W-1.
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- rt  in  5  IR[20:16], selects bltz/bgez for op=000001.
- zero  in  1  ALU zero flag.
- alu_lsb  in  1  ALU result bit 0, used for the slt-based branches.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data write strobe.
- mem_bytes  out  2  access size: 0 word, 1 byte, 2 half.
- ld_sign  out  1  sign-extend load data.
- pc_we  out  1  PC load enable.
- pc_src  out  2  next-PC select: 0 ALU result, 1 branch target register, 2 jump target, 3 rs (jr/jalr).
- ir_we  out  1  IR load enable.
- reg_we  out  1  register file write.
- reg_dst  out  2  destination select: 0 rt, 1 rd, 2 $31.
- wb_sel  out  2  write-back select: 0 ALUOut, 1 MDR, 2 PC.
- alu_a  out  2  ALU A select: 0 PC, 1 rs, 2 shamt.
- alu_b  out  2  ALU B select: 0 rt, 1 const 4, 2 ext imm, 3 ext imm<<2.
- imm_sign  out  1  sign-extend imm16.
- alu_op  out  4  ALU operation code (see Behaviour).
- state  out  4  current state, for debug.
- bus_err  out  1  sticky memory timeout.
- ill_err  out  1  sticky illegal-instruction flag.
- retired  out  RETIRE_W  count of completed instructions.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to FETCH; watchdog, retired, bus_err and ill_err clear to 0.
  - All enables and strobes are 0; selects are 0 except imem_req.
  - imem_req=1 on the first post-reset FETCH cycle, since outputs are decoded from state.
  - Reset mid-wait abandons the access. The memory sees req drop in the same cycle.
- alu_op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI.
- States: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEMADR 4, MEMRD 5, MEMWR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JUMP 10, ERR 15.
- FETCH:
  - Outputs: imem_req=1, alu_a=0, alu_b=1, alu_op=ADD.
  - When imem_ready=1: ir_we=1, pc_we=1, pc_src=0, go to DECODE. Otherwise hold.
- DECODE:
  - Outputs: alu_a=0, alu_b=3, imm_sign=1, alu_op=ADD, so the branch target is latched.
  - Dispatch:
    - R-type → EXEC_R (jr/jalr → JUMP).
    - ALU-immediate → EXEC_I.
    - Load/store → MEMADR.
    - beq/bne/blez/bgtz/bltz/bgez → BRANCH.
    - j/jal → JUMP.
    - Any other opcode or funct → ERR with ill_err=1.
- EXEC_R / EXEC_I:
  - Shifts sll/srl/sra use alu_a=2. Variable shifts use alu_a=1.
  - imm_sign=0 for andi/ori/xori; imm_sign=1 otherwise.
  - Both go to WB_ALU.
- WB_ALU: reg_we=1, wb_sel=0; reg_dst=1 for R-type, 0 otherwise → FETCH.
- MEMADR: alu_a=1, alu_b=2, imm_sign=1, ADD → MEMRD for loads, MEMWR for stores.
- MEMRD / MEMWR:
  - dmem_req=1 (dmem_we=1 in MEMWR); mem_bytes and ld_sign held stable.
  - When dmem_ready=1: MEMRD → WB_MEM, MEMWR → FETCH.
- WB_MEM: reg_we=1, wb_sel=1, reg_dst=0 → FETCH.
- BRANCH:
  - ALU compares: beq/bne use SUB with zero; blez/bgtz/bltz/bgez use SLT against $0.
  - When the condition is true: pc_we=1, pc_src=1.
  - Always → FETCH.
- JUMP:
  - pc_we=1; pc_src=2 for j/jal, 3 for jr/jalr.
  - jal/jalr: reg_we=1, wb_sel=2; reg_dst=2 for jal, 1 for jalr. PC already holds PC+4.
  - → FETCH.
- Watchdog:
  - Counts each cycle spent in FETCH, MEMRD or MEMWR with ready=0, and clears on state exit.
  - If the count reaches MEM_TMO while ready is still 0: go to ERR and set bus_err.
  - Ready arriving in the same cycle the count hits MEM_TMO wins: normal transition, no error.
- ERR: all outputs idle; the state is held until reset.
- retired: increments by 1 (modulo 2^RETIRE_W) on every transition into FETCH from a non-reset state.
- Latencies with ready asserted in the first cycle:
  - R/I-ALU: 4 cycles. Load: 5. Store: 4. Branch: 3. Jump: 3.
  - Each wait cycle adds 1.

Test Plan:
- Reset → state=0, imem_req=1, all other outputs 0. Release rst with imem_ready=1 and IR=add ($op=0,funct=0x20) → states 0,1,2,7,0; reg_we=1 with reg_dst=1 in WB_ALU; retired=1.
- lw (op 0x23) with dmem_ready delayed 3 cycles → MEMRD held 4 cycles, dmem_req=1 throughout; WB_MEM has wb_sel=1; total latency 8 cycles.
- beq with zero=1 → pc_we=1, pc_src=1 in BRANCH. bne with zero=1 → pc_we=0. Both take 3 cycles.
- jal (op 0x03) → JUMP outputs pc_src=2, reg_dst=2, wb_sel=2, reg_we=1, pc_we=1.
- imem_ready held 0 with MEM_TMO=12 → ERR after 12 wait cycles, bus_err=1 and sticky. Ready at wait-count 12 → no error.
- Opcode 0x3F → ERR, ill_err=1, retired unchanged. Async rst pulse → returns to FETCH with flags clear.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mips_mc_ctrl
// Purpose : Multi-cycle MIPS control unit. It steps each instruction through a
//           small state machine. One ALU is shared between PC increment,
//           address generation and execute. Instruction and data memory use
//           req/ready handshakes that are guarded by a watchdog timeout.
// Ports   : clk, rst (async, active-low)
//           op/funct/rt      - IR fields used for decode
//           zero/alu_lsb     - ALU status used for branch resolution
//           imem_ready/dmem_ready - memory handshakes
//           imem_req, dmem_req, dmem_we, mem_bytes, ld_sign - memory control
//           pc_we, pc_src, ir_we, reg_we, reg_dst, wb_sel   - datapath enables
//           alu_a, alu_b, imm_sign, alu_op                  - ALU control
//           state, bus_err, ill_err, retired                - status/debug
// Revision: 1.0 - initial release
// ============================================================================
module mips_mc_ctrl #(
  parameter int TMO_W    = 4,
  parameter int MEM_TMO  = 12,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic [4:0]          rt,
  input  logic                zero,
  input  logic                alu_lsb,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [1:0]          mem_bytes,
  output logic                ld_sign,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                ir_we,
  output logic                reg_we,
  output logic [1:0]          reg_dst,
  output logic [1:0]          wb_sel,
  output logic [1:0]          alu_a,
  output logic [1:0]          alu_b,
  output logic                imm_sign,
  output logic [3:0]          alu_op,
  output logic [3:0]          state,
  output logic                bus_err,
  output logic                ill_err,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3,
    S_MEMADR = 4'd4,  S_MEMRD  = 4'd5,  S_MEMWR  = 4'd6,  S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_ERR    = 4'd15
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,  ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6,  ALU_SLTU = 4'd7,
    ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11
  } alu_e;

  state_e              state_q, state_d;
  logic [TMO_W-1:0]    wdog_q, wdog_d;
  logic                bus_err_q, bus_err_d;
  logic                ill_err_q, ill_err_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  // ---------------------------------------------------------------- decode
  logic r_ok, r_shamt, r_jr, r_jalr;
  alu_e r_aop;
  always_comb begin
    r_ok    = 1'b1;
    r_shamt = 1'b0;
    r_jr    = 1'b0;
    r_jalr  = 1'b0;
    r_aop   = ALU_ADD;
    case (funct)
      6'h00:         begin r_aop = ALU_SLL; r_shamt = 1'b1; end
      6'h02:         begin r_aop = ALU_SRL; r_shamt = 1'b1; end
      6'h03:         begin r_aop = ALU_SRA; r_shamt = 1'b1; end
      6'h04:         r_aop = ALU_SLL;
      6'h06:         r_aop = ALU_SRL;
      6'h07:         r_aop = ALU_SRA;
      6'h08:         r_jr   = 1'b1;
      6'h09:         r_jalr = 1'b1;
      6'h20, 6'h21:  r_aop = ALU_ADD;
      6'h22, 6'h23:  r_aop = ALU_SUB;
      6'h24:         r_aop = ALU_AND;
      6'h25:         r_aop = ALU_OR;
      6'h26:         r_aop = ALU_XOR;
      6'h27:         r_aop = ALU_NOR;
      6'h2A:         r_aop = ALU_SLT;
      6'h2B:         r_aop = ALU_SLTU;
      default:       r_ok = 1'b0;
    endcase
  end

  logic i_ok, i_zext;
  alu_e i_aop;
  always_comb begin
    i_ok   = 1'b1;
    i_zext = 1'b0;
    i_aop  = ALU_ADD;
    case (op)
      6'h08, 6'h09: i_aop = ALU_ADD;
      6'h0A:        i_aop = ALU_SLT;
      6'h0B:        i_aop = ALU_SLTU;
      6'h0C:        begin i_aop = ALU_AND; i_zext = 1'b1; end
      6'h0D:        begin i_aop = ALU_OR;  i_zext = 1'b1; end
      6'h0E:        begin i_aop = ALU_XOR; i_zext = 1'b1; end
      6'h0F:        i_aop = ALU_LUI;
      default:      i_ok = 1'b0;
    endcase
  end

  logic is_r, is_load, is_store, is_br, is_j;
  assign is_r     = (op == 6'h00);
  assign is_load  = (op == 6'h20) || (op == 6'h21) || (op == 6'h23) ||
                    (op == 6'h24) || (op == 6'h25);
  assign is_store = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
  assign is_br    = ((op >= 6'h04) && (op <= 6'h07)) ||
                    ((op == 6'h01) && (rt <= 5'd1));
  assign is_j     = (op == 6'h02) || (op == 6'h03);

  // Size from the low opcode bits (x0 byte, x1 half, x3 word); bit 2 marks
  // the unsigned load variants.
  logic [1:0] acc_bytes;
  always_comb begin
    case (op[1:0])
      2'b00:   acc_bytes = 2'd1;
      2'b01:   acc_bytes = 2'd2;
      default: acc_bytes = 2'd0;
    endcase
  end

  // The datapath's zero flag reports operand equality (A == B), so it is
  // still meaningful while the ALU performs SLT against $0 for blez/bgtz.
  logic br_taken;
  always_comb begin
    case (op)
      6'h04:   br_taken = zero;
      6'h05:   br_taken = ~zero;
      6'h06:   br_taken = alu_lsb | zero;
      6'h07:   br_taken = ~alu_lsb & ~zero;
      default: br_taken = rt[0] ? ~alu_lsb : alu_lsb;
    endcase
  end

  // ---------------------------------------------------------------- watchdog
  logic wait_st, ready, tmo;
  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign ready   = (state_q == S_FETCH) ? imem_ready : dmem_ready;
  // Compare before incrementing so that a ready in the timeout cycle still wins.
  assign tmo     = (wdog_q == TMO_W'(MEM_TMO));
  assign wdog_d  = (wait_st && !ready && !tmo) ? wdog_q + TMO_W'(1) : '0;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q;
    ill_err_d = ill_err_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    mem_bytes = 2'd0;
    ld_sign   = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = 2'd0;
    wb_sel    = 2'd0;
    alu_a     = 2'd0;
    alu_b     = 2'd0;
    imm_sign  = 1'b0;
    alu_op    = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        alu_b    = 2'd1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo) begin
          bus_err_d = 1'b1;
          state_d   = S_ERR;
        end
      end
      S_DECODE: begin
        alu_b    = 2'd3;
        imm_sign = 1'b1;
        if (is_r) begin
          if (r_jr || r_jalr)  state_d = S_JUMP;
          else if (r_ok)       state_d = S_EXEC_R;
          else begin
            ill_err_d = 1'b1;
            state_d   = S_ERR;
          end
        end else if (i_ok)                 state_d = S_EXEC_I;
        else if (is_load || is_store)      state_d = S_MEMADR;
        else if (is_br)                    state_d = S_BRANCH;
        else if (is_j)                     state_d = S_JUMP;
        else begin
          ill_err_d = 1'b1;
          state_d   = S_ERR;
        end
      end
      S_EXEC_R: begin
        alu_a   = r_shamt ? 2'd2 : 2'd1;
        alu_op  = r_aop;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_a    = 2'd1;
        alu_b    = 2'd2;
        imm_sign = ~i_zext;
        alu_op   = i_aop;
        state_d  = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_we  = 1'b1;
        reg_dst = is_r ? 2'd1 : 2'd0;
        state_d = S_FETCH;
      end
      S_MEMADR: begin
        alu_a    = 2'd1;
        alu_b    = 2'd2;
        imm_sign = 1'b1;
        state_d  = is_load ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD, S_MEMWR: begin
        dmem_req  = 1'b1;
        dmem_we   = (state_q == S_MEMWR);
        mem_bytes = acc_bytes;
        ld_sign   = (state_q == S_MEMRD) & ~op[2];
        if (dmem_ready) begin
          state_d = (state_q == S_MEMRD) ? S_WB_MEM : S_FETCH;
        end else if (tmo) begin
          bus_err_d = 1'b1;
          state_d   = S_ERR;
        end
      end
      S_WB_MEM: begin
        reg_we  = 1'b1;
        wb_sel  = 2'd1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_a  = 2'd1;
        alu_op = ((op == 6'h04) || (op == 6'h05)) ? ALU_SUB : ALU_SLT;
        if (br_taken) begin
          pc_we  = 1'b1;
          pc_src = 2'd1;
        end
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_we = 1'b1;
        if (is_r) begin
          pc_src = 2'd3;
          if (r_jalr) begin
            reg_we  = 1'b1;
            wb_sel  = 2'd2;
            reg_dst = 2'd1;
          end
        end else begin
          pc_src = 2'd2;
          if (op == 6'h03) begin
            reg_we  = 1'b1;
            wb_sel  = 2'd2;
            reg_dst = 2'd2;
          end
        end
        state_d = S_FETCH;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_FETCH;
    endcase

    // Under reset the state already reads FETCH. Keep only the fetch request
    // visible so that no enable can fire (e.g. ir_we from an early imem_ready).
    if (!rst) begin
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      mem_bytes = 2'd0;
      ld_sign   = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'd0;
      ir_we     = 1'b0;
      reg_we    = 1'b0;
      reg_dst   = 2'd0;
      wb_sel    = 2'd0;
      alu_a     = 2'd0;
      alu_b     = 2'd0;
      imm_sign  = 1'b0;
      alu_op    = ALU_ADD;
      imem_req  = 1'b1;
    end
  end

  assign retired_d = ((state_d == S_FETCH) && (state_q != S_FETCH)) ?
                     retired_q + RETIRE_W'(1) : retired_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      wdog_q    <= '0;
      bus_err_q <= 1'b0;
      ill_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      bus_err_q <= bus_err_d;
      ill_err_q <= ill_err_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign bus_err = bus_err_q;
  assign ill_err = ill_err_q;
  assign retired = retired_q;

endmodule
`default_nettype wire
